// File: rtl/logarithmic_afpm_pkg.sv
// Shared FP16 field widths, constants and types for the Mitchell multiplier.
package afpm_pkg;
    localparam int EXP_W = 5;
    localparam int MAN_W = 10;
    localparam int BIAS  = 15;

    localparam logic [15:0] QNAN   = 16'h7E00;
    localparam logic [15:0] INF    = 16'h7C00;
    localparam logic [15:0] MAXFIN = 16'h7BFF;

    typedef struct packed {
        logic             s;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
    } fp16_t;

    typedef enum logic {
        PH_LO = 1'b0,
        PH_HI = 1'b1
    } phase_e;
endpackage

// File: rtl/logarithmic_afpm_if.sv
// Byte-serial harness bus: clock enable, two operand bytes, product byte.
interface afpm_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/afpm_mitchell_core.sv
// Combinational FP16 product via Mitchell's log approximation.
// AFPM_SATFINITE_EN: saturate overflow to max finite instead of Inf.
module afpm_mitchell_core
    import afpm_pkg::*;
(
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] y_o
);
    fp16_t            a;
    fp16_t            b;
    logic             s;
    logic             nan_a, nan_b;
    logic             inf_a, inf_b;
    logic             zer_a, zer_b;
    logic signed [16:0] sum;

    localparam logic signed [16:0] BIAS_SH = 17'(BIAS << MAN_W);

    assign a = a_i;
    assign b = b_i;
    assign s = a.s ^ b.s;

    assign nan_a = (a.e == '1) && (a.m != '0);
    assign nan_b = (b.e == '1) && (b.m != '0);
    assign inf_a = (a.e == '1) && (a.m == '0);
    assign inf_b = (b.e == '1) && (b.m == '0);
    assign zer_a = (a.e == '0);
    assign zer_b = (b.e == '0);

    // Adding the packed exponent:mantissa fields is the log-domain product;
    // the mantissa carry bumps the exponent for free.
    assign sum = $signed({2'b00, a.e, a.m})
               + $signed({2'b00, b.e, b.m})
               - BIAS_SH;

    always_comb begin
        y_o = '0;
        if (nan_a || nan_b || (inf_a && zer_b) || (inf_b && zer_a)) begin
            y_o = QNAN;
        end else if (inf_a || inf_b) begin
            y_o = {s, INF[14:0]};
        end else if (zer_a || zer_b) begin
            y_o = {s, 15'd0};
        end else if (sum <= 17'sh003FF) begin
            y_o = {s, 15'd0};
        end else if (sum >= 17'sh07C00) begin
`ifdef AFPM_SATFINITE_EN
            y_o = {s, MAXFIN[14:0]};
`else
            y_o = {s, INF[14:0]};
`endif
        end else begin
            y_o = {s, sum[14:0]};
        end
    end
endmodule

// File: rtl/logarithmic_afpm.sv
// Byte-serial wrapper: two-phase operand capture, product register, output mux.
module logarithmic_afpm
    import afpm_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    afpm_if.slave  bus
);
    phase_e      phase_q, phase_d;
    logic [7:0]  a_lo_q, a_lo_d;
    logic [7:0]  b_lo_q, b_lo_d;
    logic [15:0] prod_q, prod_d;
    logic [15:0] prod_c;

    afpm_mitchell_core u_core (
        .a_i ({bus.ui_in, a_lo_q}),
        .b_i ({bus.uio_in, b_lo_q}),
        .y_o (prod_c)
    );

    // rst_n is active-high here; the harness already inverts it.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            phase_q <= PH_LO;
        end else begin
            phase_q <= phase_d;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            a_lo_q <= '0;
            b_lo_q <= '0;
            prod_q <= '0;
        end else begin
            a_lo_q <= a_lo_d;
            b_lo_q <= b_lo_d;
            prod_q <= prod_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        a_lo_d  = a_lo_q;
        b_lo_d  = b_lo_q;
        prod_d  = prod_q;
        if (bus.ena) begin
            unique case (phase_q)
                PH_LO: begin
                    a_lo_d  = bus.ui_in;
                    b_lo_d  = bus.uio_in;
                    phase_d = PH_HI;
                end
                PH_HI: begin
                    prod_d  = prod_c;
                    phase_d = PH_LO;
                end
                default: phase_d = PH_LO;
            endcase
        end
    end

    always_comb begin
        bus.uo_out  = (phase_q == PH_HI) ? prod_q[15:8] : prod_q[7:0];
        bus.uio_out = '0;
        bus.uio_oe  = '0;
    end
endmodule

// File: tb/tb_logarithmic_afpm.sv
// Directed and randomized bench for logarithmic_afpm with a numeric FP16 model.
module tb_logarithmic_afpm;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [15:0] prev_exp = 16'h0000;

    afpm_if bus ();

    logarithmic_afpm dut (
        .clk   (clk),
        .rst_n (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference: separate exponent/mantissa arithmetic, log-domain rules.
    function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b);
        logic s;
        int ea, eb, ma, mb, e, m;
        logic nan_a, nan_b, inf_a, inf_b;
        s  = a[15] ^ b[15];
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        ma = int'(a[9:0]);
        mb = int'(b[9:0]);
        nan_a = (ea == 31) && (ma != 0);
        nan_b = (eb == 31) && (mb != 0);
        inf_a = (ea == 31) && (ma == 0);
        inf_b = (eb == 31) && (mb == 0);
        if (nan_a || nan_b || (inf_a && eb == 0) || (inf_b && ea == 0))
            return 16'h7E00;
        if (inf_a || inf_b)
            return {s, 15'h7C00};
        if (ea == 0 || eb == 0)
            return {s, 15'h0000};
        e = ea + eb - 15;
        m = ma + mb;
        if (m >= 1024) begin
            e = e + 1;
            m = m - 1024;
        end
        if (e <= 0)
            return {s, 15'h0000};
        if (e >= 31) begin
`ifdef AFPM_SATFINITE_EN
            return {s, 15'h7BFF};
`else
            return {s, 15'h7C00};
`endif
        end
        return {s, 5'(e), 10'(m)};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Low beat also exposes the previous product's high byte.
    task automatic low_beat(input string tag, input logic [15:0] a, input logic [15:0] b);
        bus.ena    = 1'b1;
        bus.ui_in  = a[7:0];
        bus.uio_in = b[7:0];
        tick();
        check({tag, "_prevhi"}, bus.uo_out, prev_exp[15:8]);
    endtask

    task automatic high_beat(input string tag, input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] exp);
        bus.ena    = 1'b1;
        bus.ui_in  = a[15:8];
        bus.uio_in = b[15:8];
        tick();
        check({tag, "_lo"}, bus.uo_out, exp[7:0]);
        prev_exp = exp;
    endtask

    task automatic op(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] exp);
        low_beat(tag, a, b);
        high_beat(tag, a, b, exp);
    endtask

    localparam logic [15:0] OVF_EXP =
`ifdef AFPM_SATFINITE_EN
        16'h7BFF;
`else
        16'h7C00;
`endif

    initial begin
        logic [15:0] ra, rb;
        bus.ena    = 1'b0;
        bus.ui_in  = 8'h00;
        bus.uio_in = 8'h00;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_uo", bus.uo_out, 8'h00);
        check("rst_oe", bus.uio_oe, 8'h00);
        check("rst_uio_out", bus.uio_out, 8'h00);

        op("mul_1p5x3", 16'h3E00, 16'h4200, 16'h4400);
        op("neg", 16'hBE00, 16'h4000, 16'hC200);
        op("two_sq", 16'h4000, 16'h4000, 16'h4400);
        op("zero", 16'h0000, 16'h4200, 16'h0000);
        op("negzero", 16'h8000, 16'h4200, 16'h8000);
        op("uflow", 16'h0400, 16'h0400, 16'h0000);
        op("oflow", 16'h7800, 16'h7800, OVF_EXP);
        op("inf_x_zero", 16'h7C00, 16'h0000, 16'h7E00);
        op("neg_inf", 16'hFC00, 16'h4000, 16'hFC00);
        op("nan", 16'h7C01, 16'hC000, 16'h7E00);
        op("carry", 16'h3E00, 16'h3E00, 16'h4000);

        // Stall between beats: outputs and captured low bytes must hold.
        low_beat("hold", 16'h3E00, 16'h4200);
        bus.ena    = 1'b0;
        bus.ui_in  = 8'hA5;
        bus.uio_in = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_uo", bus.uo_out, prev_exp[15:8]);
        end
        high_beat("hold", 16'h3E00, 16'h4200, 16'h4400);

        // Reset after a low beat: next beat must again be a low byte.
        low_beat("rstmid", 16'h3E01, 16'h4203);
        rst = 1'b1;
        #2;
        check("rstmid_uo", bus.uo_out, 8'h00);
        tick();
        rst = 1'b0;
        prev_exp = 16'h0000;
        op("after_rst", 16'hBE00, 16'h4000, 16'hC200);

        for (int i = 0; i < 60; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 4 == 0) ra[14:10] = 5'(15 + $urandom_range(0, 3));
            if (i % 4 == 0) rb[14:10] = 5'(14 + $urandom_range(0, 3));
            op("rand", ra, rb, model(ra, rb));
        end
        low_beat("drain", 16'h0000, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/logarithmic_afpm.md
# logarithmic_afpm

Approximate FP16 (IEEE binary16) multiplier based on Mitchell's logarithmic approximation. Each operand arrives as two byte-serial beats on 8-bit buses. The product is returned as two byte-serial beats on an 8-bit output. The block sits behind the TinyTapeout-style user-project harness as the streaming arithmetic core.

## Interface
- Parameters: none.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, **active-high** reset. The name is kept for harness compatibility; the harness presents it already inverted.
- `ena`  in  1  clock enable; 0 holds all state.
- `ui_in`  in  8  operand A byte (low byte on phase 0, high byte on phase 1).
- `uio_in`  in  8  operand B byte (same phasing).
- `uo_out`  out  8  product byte (low byte on phase 0, high byte on phase 1).
- `uio_out`  out  8  tied to 0.
- `uio_oe`  out  8  tied to 0 (all uio pins are inputs).

## Operation
- State:
  - `phase` (1 bit)
  - `a_lo`, `b_lo` (8 bits each)
  - `prod` (16 bits)
- On each enabled edge:
  - phase 0: `a_lo<=ui_in`, `b_lo<=uio_in`, `phase<=1`.
  - phase 1: `A={ui_in,a_lo}`, `B={uio_in,b_lo}`; `prod<=f(A,B)`, `phase<=0`.
- Output mux: `uo_out = phase ? prod[15:8] : prod[7:0]`.
- f(A,B), evaluated in this priority order:
  - Sign: `s = sA ^ sB`, applied to every result below, including zero and Inf.
  - NaN: if either operand is NaN (exp=31, mant≠0), or Inf×zero, the result is 0x7E00 (sign ignored).
  - Inf: if either operand is Inf, the result is {s,0x7C00}.
  - Zero: if either exponent field is 0 (zero or subnormal, flushed), the result is signed zero.
  - Normal path: `S = {1'b0,eA,mA} + {1'b0,eB,mB} − (15<<10)`, computed as signed 17-bit.
    - S ≤ 0x03FF (exponent ≤ 0): signed zero.
    - S ≥ 0x7C00 (exponent ≥ 31): overflow, see Configuration.
    - Otherwise: `{s, S[14:0]}`.
  - The mantissa carry into the exponent is native to the addition. There is no rounding; the approximation is exact when either mantissa is 0.

## Timing
- Reset values: `phase=0`, `a_lo=b_lo=0`, `prod=0`, hence `uo_out=0x00`. `uio_out` and `uio_oe` are always 0.
- One operand pair takes 2 cycles. Throughput is one product per 2 cycles, fully pipelined with input capture.
- Cycle sequence, with edge k in phase 0:
  - Edge k captures the low bytes.
  - Edge k+1 captures the high bytes and registers `prod`.
  - After edge k+1, `uo_out` = `prod[7:0]`.
  - After edge k+2, `uo_out` = `prod[15:8]`. Edge k+2 also captures the next low bytes.
- `prod` is stable from edge k+1 until edge k+3.
- `ena=0`: phase, operand and product registers all hold; `uo_out` holds its current byte.
- Reset mid-operation discards any captured low bytes and the product. The next enabled edge after release is phase 0.
- No handshake. Sources must present one byte per enabled cycle, aligned to phase.

## Configuration
- `AFPM_SATFINITE_EN`:
  - Defined: normal-path overflow saturates to {s,0x7BFF}.
  - Undefined: overflow yields {s,0x7C00} (Inf).
  - Inf and NaN inputs behave identically in both builds.

## Structure
- Package `afpm_pkg` holds:
  - field widths: EXP_W=5, MAN_W=10
  - `BIAS=15`
  - constants `QNAN=16'h7E00`, `INF=16'h7C00`, `MAXFIN=16'h7BFF`
  - an FP16 field-extraction typedef
- Sub-module `afpm_mitchell_core`: purely combinational f(A,B), containing all special-case and exponent logic.
- The top-level module contains only the phase FSM, byte registers and output mux.

## Test plan
- Reset with `rst_n=1`, then release: `uo_out=0x00` and `uio_oe=0x00` before any operand is applied.
- A=0x3E00 (1.5), B=0x4200 (3.0), driven as low bytes 00/00 then high bytes 3E/42 → `uo_out` = 0x00 then 0x44 (0x4400, approximately 4.0).
- A=0xBE00, B=0x4000 → 0xC200; A=0x4000, B=0x4000 → 0x4400.
- Zero and underflow:
  - A=0x0000, B=0x4200 → 0x0000.
  - A=0x8000, B=0x4200 → 0x8000.
  - A=0x0400, B=0x0400 → 0x0000.
- Specials:
  - 0x7800×0x7800 → 0x7C00; with `AFPM_SATFINITE_EN`, 0x7BFF.
  - 0x7C00×0x0000 → 0x7E00.
  - 0xFC00×0x4000 → 0xFC00.
- Control:
  - Hold `ena=0` for 3 cycles between the low and high beats → result is unchanged.
  - Assert reset after the low beat → the next beat is treated as a low byte.
